// File: rtl/lead_count_normalizer_pkg.sv
// lead_count_pkg: shared state encoding, default sizing and lead-bit constants
// for the lead count normalizer.
package lead_count_pkg;
  typedef enum logic [1:0] {IDLE, COARSE, FINE, DONE} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH) + 1;
  localparam logic LEAD_ZERO = 1'b0;
  localparam logic LEAD_ONE = 1'b1;
endpackage

// File: rtl/lead_count_normalizer_lead_detect.sv
// lead_detect: compares the top STEP bits of the working operand against the lead bit.
module lead_detect
  import lead_count_pkg::*;
#(
  parameter int STEP = DEF_STEP
) (
  input  logic [STEP-1:0] opnd_i,
  input  logic            lead_i,
  output logic            all_lead_o,
  output logic            msb_lead_o
);
  assign all_lead_o = opnd_i == {STEP{lead_i}};
  assign msb_lead_o = opnd_i[STEP-1] == lead_i;
endmodule

// File: rtl/lead_count_normalizer.sv
// lead_count_normalizer: multi-cycle CLZ/CLO with normalizing left shift.
// Optional LEAD_COUNT_ZERO_DETECT_EN short-cuts all-lead operands on accept.
module lead_count_normalizer
  import lead_count_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clo,
  input  logic [WIDTH-1:0]       a,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(WIDTH):0] count,
  output logic [WIDTH-1:0]       normalized
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CSTEP = CW'(STEP);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e state_q, state_d;
  logic [WIDTH-1:0] opnd_q, opnd_d, norm_q, norm_d;
  logic [CW-1:0] cnt_q, cnt_d, count_q, count_d;
  logic lead_q, lead_d, all_lead, msb_lead, accept, a_all_lead;

  assign accept = (state_q == IDLE) && start;

`ifdef LEAD_COUNT_ZERO_DETECT_EN
  assign a_all_lead = a == {WIDTH{clo}};
`else
  assign a_all_lead = 1'b0;
`endif

  lead_detect #(.STEP(STEP)) u_detect (
    .opnd_i     (opnd_q[WIDTH-1 -: STEP]),
    .lead_i     (lead_q),
    .all_lead_o (all_lead),
    .msb_lead_o (msb_lead)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? COARSE : IDLE;
      COARSE:  state_d = (cnt_q == FULL) ? DONE : all_lead ? COARSE : FINE;
      FINE:    state_d = (cnt_q == FULL || !msb_lead) ? DONE : FINE;
      default: state_d = IDLE;
    endcase
  end

  // An all-lead operand is preloaded as fully shifted so COARSE exits at once.
  always_comb begin
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    lead_d  = lead_q;
    count_d = count_q;
    norm_d  = norm_q;
    if (accept) begin
      lead_d = clo ? LEAD_ONE : LEAD_ZERO;
      opnd_d = a_all_lead ? '0 : a;
      cnt_d  = a_all_lead ? FULL : '0;
    end else if (state_q == COARSE && state_d == COARSE) begin
      opnd_d = opnd_q << STEP;
      cnt_d  = cnt_q + CSTEP;
    end else if (state_q == FINE && state_d == FINE) begin
      opnd_d = opnd_q << 1;
      cnt_d  = cnt_q + ONE;
    end
    if (state_q != DONE && state_d == DONE) begin
      count_d = cnt_q;
      norm_d  = opnd_q;
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      opnd_q  <= '0;
      cnt_q   <= '0;
      lead_q  <= LEAD_ZERO;
      count_q <= '0;
      norm_q  <= '0;
    end else begin
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      lead_q  <= lead_d;
      count_q <= count_d;
      norm_q  <= norm_d;
    end

  always_comb begin
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    count      = count_q;
    normalized = norm_q;
  end
endmodule

// File: tb/tb_lead_count_normalizer.sv
// tb_lead_count_normalizer: directed vectors for the CLZ/CLO normalizer (WIDTH=32, STEP=4).
module tb_lead_count_normalizer;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, clo = 1'b0;
  logic [31:0] a = '0;
  logic        busy, done;
  logic [5:0]  count;
  logic [31:0] normalized;
  int n_chk = 0, n_fail = 0;

`ifdef LEAD_COUNT_ZERO_DETECT_EN
  localparam int ZCYC = 2;
`else
  localparam int ZCYC = 10;
`endif

  always #5 clk = ~clk;

  lead_count_normalizer #(.WIDTH(32), .STEP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clo        (clo),
    .a          (a),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .normalized (normalized)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int got = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) check({tag, ".busy1"}, 64'(busy), 64'd1);
      if (done) begin
        got = k;
        break;
      end
    end
    check({tag, ".cyc"}, 64'(got), 64'(exp_cyc));
  endtask

  task automatic run(input string tag, input logic c, input logic [31:0] v,
                     input int cyc, input int cnt, input logic [31:0] nrm);
    @(negedge clk);
    start = 1'b1; clo = c; a = v;
    @(posedge clk);
    #1 start = 1'b0; a = ~v; clo = ~c;
    wait_done(tag, cyc);
    check({tag, ".count"}, 64'(count), 64'(cnt));
    check({tag, ".norm"}, 64'(normalized), 64'(nrm));
    check({tag, ".busy_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
    check({tag, ".done_after"}, 64'(done), 64'd0);
    check({tag, ".count_held"}, 64'(count), 64'(cnt));
  endtask

  initial begin
    logic seen;
    repeat (2) @(negedge clk);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.norm", 64'(normalized), 64'd0);
    reset = 1'b1;

    run("clz_1000", 1'b0, 32'h0000_1000, 10, 19, 32'h8000_0000);

    @(negedge clk);
    start = 1'b1; clo = 1'b0; a = 32'h0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst.busy_pre", 64'(busy), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.count", 64'(count), 64'd0);
    check("midrst.norm", 64'(normalized), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midrst.no_done", 64'(seen), 64'd0);

    run("clz_msb", 1'b0, 32'h8000_0000, 3, 0, 32'h8000_0000);
    run("clz_zero", 1'b0, 32'h0000_0000, ZCYC, 32, 32'h0);
    run("clz_step", 1'b0, 32'h0F00_0000, 4, 4, 32'hF000_0000);
    run("clo_fff", 1'b1, 32'hFFF0_0000, 6, 12, 32'h0);
    run("clo_7ff", 1'b1, 32'h7FFF_FFFF, 3, 0, 32'h7FFF_FFFF);
    run("clo_ones", 1'b1, 32'hFFFF_FFFF, ZCYC, 32, 32'h0);

    @(negedge clk);
    start = 1'b1; clo = 1'b0; a = 32'h1;
    @(posedge clk);
    #1 a = 32'h2;
    wait_done("hold", 13);
    check("hold.count", 64'(count), 64'd31);
    check("hold.norm", 64'(normalized), 64'h8000_0000);
    @(negedge clk);
    check("hold.busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("reacc", 12);
    check("reacc.count", 64'(count), 64'd30);
    check("reacc.norm", 64'(normalized), 64'h8000_0000);
    @(negedge clk);
    check("reacc.busy_after", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
